// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Data-port bundle between the MEM stage (master) and the data memory
// responder (slave).
//   dREN/dWEN/datomic : request strobes, held by the master until dhit
//   daddr/dstore      : byte address and store data
//   ccinv/ccaddr      : snoop invalidate from the other core
//   dhit/dload        : one-cycle response strobe and read / SC result
//   linkvalid         : LL/SC link register state (visibility only)
//   derr              : misaligned-access flag
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        dREN;
  logic        dWEN;
  logic        datomic;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ccinv;
  logic [31:0] ccaddr;
  logic        dhit;
  logic [31:0] dload;
  logic        linkvalid;
  logic        derr;

  modport master (
    output dREN, dWEN, datomic, daddr, dstore, ccinv, ccaddr,
    input  dhit, dload, linkvalid, derr
  );

  modport slave (
    input  dREN, dWEN, datomic, daddr, dstore, ccinv, ccaddr,
    output dhit, dload, linkvalid, derr
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-addressed data memory with LAT wait states and an LL/SC link
// register, answering MEM-stage requests.
//   CLK   : clock, all state updates on the rising edge
//   nRST  : synchronous active-low reset
//   bus   : dmem_responder_if.slave (request, snoop and response signals)
// Parameters:
//   DEPTH : number of 32-bit words (power of two)
//   LAT   : wait-state cycles between acceptance and dhit (0..15)
// Build option:
//   DMEM_ALIGN_CHK_EN : when defined, requests with daddr[1:0] != 0 finish
//                       with derr=1, no write, dload=0, link untouched.
//                       When undefined, daddr[1:0] is ignored, derr=0.
//
// state  | meaning
// IDLE   | waiting for dREN|dWEN, request latched on acceptance
// WAIT   | counting wait states, aborts if the request is dropped
// RESP   | dhit=1 for one cycle, operation performed at the closing edge
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  dmem_responder_if.slave   bus
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_next;

  logic               r_wr;
  logic               r_atomic;
  logic               r_mis;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_data;
  logic [IDX_W-1:0]   r_link;
  logic               r_linkvalid;
  logic [31:0]        r_mem [DEPTH];

  logic               w_req;
  logic               w_resp;
  logic               w_mis_in;
  logic               w_cc_hit;
  logic               w_sc_ok;
  logic               w_do_write;
  logic               w_unused_bits;

  assign w_req  = bus.dREN | bus.dWEN;
  assign w_resp = (r_state == S_RESP);

`ifdef DMEM_ALIGN_CHK_EN
  assign w_mis_in      = (bus.daddr[1:0] != 2'b00);
  assign w_unused_bits = ^{bus.daddr[31:2+IDX_W], bus.ccaddr[31:2+IDX_W],
                           bus.ccaddr[1:0]};
`else
  assign w_mis_in      = 1'b0;
  assign w_unused_bits = ^{bus.daddr[31:2+IDX_W], bus.daddr[1:0],
                           bus.ccaddr[31:2+IDX_W], bus.ccaddr[1:0]};
`endif

  // Snoop is compared against the link every cycle, whatever the FSM does.
  assign w_cc_hit = bus.ccinv && (bus.ccaddr[2+:IDX_W] == r_link);

  // A snoop hitting the link in the SC's own response cycle makes it fail.
  assign w_sc_ok    = r_linkvalid && (r_link == r_idx) && !w_cc_hit;
  assign w_do_write = w_resp && r_wr && !r_mis && (!r_atomic || w_sc_ok);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LAT == 0) begin
            w_next     = S_RESP;
            w_cnt_next = 4'd0;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = LAT_C;
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_next     = S_IDLE;
          w_cnt_next = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_next     = S_RESP;
            w_cnt_next = 4'd0;
          end
        end
      end
      S_RESP: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    bus.dhit      = w_resp;
    bus.linkvalid = r_linkvalid;
    bus.dload     = 32'd0;
    if (w_resp && !r_mis) begin
      if (r_wr) begin
        if (r_atomic) begin
          bus.dload = {31'd0, w_sc_ok};
        end
      end else begin
        bus.dload = r_mem[r_idx];
      end
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  assign bus.derr = w_resp && r_mis;
`else
  assign bus.derr = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wr        <= 1'b0;
      r_atomic    <= 1'b0;
      r_mis       <= 1'b0;
      r_idx       <= '0;
      r_data      <= 32'd0;
      r_link      <= '0;
      r_linkvalid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;

      if (r_state == S_IDLE && w_req) begin
        r_wr     <= bus.dWEN;  // dREN+dWEN together is a write
        r_atomic <= bus.datomic;
        r_idx    <= bus.daddr[2+:IDX_W];
        r_data   <= bus.dstore;
        r_mis    <= w_mis_in;
      end

      if (w_do_write) begin
        r_mem[r_idx] <= r_data;
      end

      if (w_cc_hit) begin
        r_linkvalid <= 1'b0;
      end

      // Placed after the snoop clear so an LL in RESP wins over a snoop.
      if (w_resp && !r_mis) begin
        if (r_wr) begin
          if (r_atomic || (r_idx == r_link)) begin
            r_linkvalid <= 1'b0;
          end
        end else if (r_atomic) begin
          r_linkvalid <= 1'b1;
          r_link      <= r_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed stimulus for dmem_responder. Each request pushes its expected
// response into a scoreboard queue; a negedge monitor pops and compares on
// every dhit and checks dload stays 0 between responses.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] dload;
    logic        derr;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (bus.dhit === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dhit: got dhit=1, expected dhit=0");
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_dload"}, bus.dload, e.dload);
          check({e.name, "_derr"}, 32'(bus.derr), 32'(e.derr));
        end
      end else begin
        check("quiet_dload", bus.dload, 32'd0);
      end
    end
  end

  task automatic req(input string name, input bit rd, input bit wr,
                     input bit at, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_dload,
                     input bit exp_derr, input bit cc_en,
                     input logic [31:0] cc_a);
    exp_t e;
    int   n;
    bit   got;
    e.dload = exp_dload;
    e.derr  = exp_derr;
    e.name  = name;
    sb_q.push_back(e);
    bus.dREN    = rd;
    bus.dWEN    = wr;
    bus.datomic = at;
    bus.daddr   = addr;
    bus.dstore  = data;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (bus.dhit === 1'b1) got = 1'b1;
    end
    if (got && cc_en) begin
      bus.ccinv  = 1'b1;
      bus.ccaddr = cc_a;
    end
    bus.dREN    = 1'b0;
    bus.dWEN    = 1'b0;
    bus.datomic = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no dhit in %0d cycles, expected dhit", name, n);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end else begin
      check({name, "_latency"}, 32'(n), 32'(LAT + 1));
    end
    @(posedge CLK);
    #1;
    bus.ccinv  = 1'b0;
    bus.ccaddr = 32'd0;
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
    req(name, 1'b0, 1'b1, 1'b0, a, d, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    req(name, 1'b1, 1'b0, 1'b0, a, 32'd0, exp, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.dREN    = 1'b0;
    bus.dWEN    = 1'b0;
    bus.datomic = 1'b0;
    bus.daddr   = 32'd0;
    bus.dstore  = 32'd0;
    bus.ccinv   = 1'b0;
    bus.ccaddr  = 32'd0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_dhit", 32'(bus.dhit), 32'd0);
    check("rst_dload", bus.dload, 32'd0);
    check("rst_linkvalid", 32'(bus.linkvalid), 32'd0);
    check("rst_derr", 32'(bus.derr), 32'd0);
    nRST   = 1'b1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    // Basic write then read
    wr("wr40", 32'h40, 32'hDEADBEEF);
    rd("rd40", 32'h40, 32'hDEADBEEF);

    // LL / SC success, then SC without link
    wr("wr80", 32'h80, 32'h5);
    req("ll80", 1'b1, 1'b0, 1'b1, 32'h80, 32'd0, 32'h5, 1'b0, 1'b0, 32'd0);
    check("lv_after_ll", 32'(bus.linkvalid), 32'd1);
    req("sc80_ok", 1'b0, 1'b1, 1'b1, 32'h80, 32'h9, 32'd1, 1'b0, 1'b0, 32'd0);
    check("lv_after_sc", 32'(bus.linkvalid), 32'd0);
    rd("rd80_9", 32'h80, 32'h9);
    req("sc80_nolink", 1'b0, 1'b1, 1'b1, 32'h80, 32'hA, 32'd0, 1'b0, 1'b0, 32'd0);
    rd("rd80_still9", 32'h80, 32'h9);

    // Plain write to the linked word breaks the link
    req("ll80_b", 1'b1, 1'b0, 1'b1, 32'h80, 32'd0, 32'h9, 1'b0, 1'b0, 32'd0);
    wr("wr80_7", 32'h80, 32'h7);
    check("lv_after_plain_wr", 32'(bus.linkvalid), 32'd0);
    req("sc80_broken", 1'b0, 1'b1, 1'b1, 32'h80, 32'h9, 32'd0, 1'b0, 1'b0, 32'd0);
    rd("rd80_7", 32'h80, 32'h7);

    // Snoop during SC response: matching fails it, other address does not
    req("ll80_c", 1'b1, 1'b0, 1'b1, 32'h80, 32'd0, 32'h7, 1'b0, 1'b0, 32'd0);
    req("sc80_snooped", 1'b0, 1'b1, 1'b1, 32'h80, 32'h9, 32'd0, 1'b0, 1'b1, 32'h80);
    check("lv_after_snooped_sc", 32'(bus.linkvalid), 32'd0);
    rd("rd80_7b", 32'h80, 32'h7);
    req("ll80_d", 1'b1, 1'b0, 1'b1, 32'h80, 32'd0, 32'h7, 1'b0, 1'b0, 32'd0);
    req("sc80_othersnoop", 1'b0, 1'b1, 1'b1, 32'h80, 32'h9, 32'd1, 1'b0, 1'b1, 32'h84);
    rd("rd80_9b", 32'h80, 32'h9);

    // Write aborted in WAIT leaves memory untouched
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h10;
    bus.dstore = 32'h1234;
    @(posedge CLK);
    #1;
    bus.dWEN = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    rd("rd10_after_abort", 32'h10, 32'h0);

    // Address wraps modulo DEPTH words
    wr("wr_wrap", 32'h40 + 32'(DEPTH * 4), 32'h55);
    rd("rd40_wrap", 32'h40, 32'h55);

    // dREN and dWEN together act as a write
    req("both_rw", 1'b1, 1'b1, 1'b0, 32'h44, 32'hA5A5, 32'd0, 1'b0, 1'b0, 32'd0);
    rd("rd44", 32'h44, 32'hA5A5);

    // Snoop while idle
    req("ll20", 1'b1, 1'b0, 1'b1, 32'h20, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    bus.ccinv  = 1'b1;
    bus.ccaddr = 32'h24;
    @(posedge CLK);
    #1;
    bus.ccinv = 1'b0;
    check("lv_other_snoop", 32'(bus.linkvalid), 32'd1);
    bus.ccinv  = 1'b1;
    bus.ccaddr = 32'h20;
    @(posedge CLK);
    #1;
    bus.ccinv = 1'b0;
    check("lv_match_snoop", 32'(bus.linkvalid), 32'd0);

    // LL beats a matching snoop in the same cycle
    req("ll24", 1'b1, 1'b0, 1'b1, 32'h24, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    req("ll24_snooped", 1'b1, 1'b0, 1'b1, 32'h24, 32'd0, 32'd0, 1'b0, 1'b1, 32'h24);
    check("lv_ll_wins", 32'(bus.linkvalid), 32'd1);

`ifdef DMEM_ALIGN_CHK_EN
    req("wr42_mis", 1'b0, 1'b1, 1'b0, 32'h42, 32'h1111, 32'd0, 1'b1, 1'b0, 32'd0);
    rd("rd40_after_mis", 32'h40, 32'h55);
    req("sc26_mis", 1'b0, 1'b1, 1'b1, 32'h26, 32'h2222, 32'd0, 1'b1, 1'b0, 32'd0);
    check("lv_after_mis_sc", 32'(bus.linkvalid), 32'd1);
    rd("rd24_after_mis", 32'h24, 32'h0);
`endif

    // Reset in the middle of a write: no dhit, everything cleared
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h30;
    bus.dstore = 32'h77;
    @(posedge CLK);
    #1;
    nRST     = 1'b0;
    bus.dWEN = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_dhit", 32'(bus.dhit), 32'd0);
    check("midrst_dload", bus.dload, 32'd0);
    check("midrst_linkvalid", 32'(bus.linkvalid), 32'd0);
    check("midrst_derr", 32'(bus.derr), 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    rd("rd30_after_rst", 32'h30, 32'h0);
    rd("rd40_after_rst", 32'h40, 32'h0);
    rd("rd80_after_rst", 32'h80, 32'h0);

    repeat (2) @(posedge CLK);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
